// File: rtl/qoi_stream_sequencer.sv
// QOI stream sequencer: parses the 14-byte header, keeps the decoder's 5-byte chunk
// window filled, issues one decoder step per pixel and verifies the 8-byte end marker.
module qoi_stream_sequencer #(
   parameter int DIM_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [39:0]      chunk_flat,
   input  logic [2:0]       dec_consumed,
   output logic             dec_step,
   output logic             dec_clear,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [DIM_W-1:0] img_width,
   output logic [DIM_W-1:0] img_height,
   output logic [7:0]       img_channels,
   output logic             busy,
   output logic             done,
   output logic             error,
   input  logic             start
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX, S_END, S_DONE, S_ERR} state_t;

   state_t             state;
   logic [7:0]         win [5];
   logic [2:0]         fill;
   logic [3:0]         hdr_cnt;
   logic [3:0]         end_cnt;
   logic [23:0]        dim_sh;
   logic [2*DIM_W-1:0] total;
   logic [2*DIM_W-1:0] pix_cnt;

   logic               acc;
   logic               win_acc;
   logic               end_ret;
   logic               bad_cons;
   logic [2:0]         sh;
   logic [2:0]         base;
   logic [3:0]         idx;
   logic [7:0]         nxt_win [5];
   logic [2:0]         nxt_fill;
   logic [31:0]        dim_full;
   logic [4:0]         end_room;
   logic [7:0]         magic_b;
   logic               dim_bad;

   assign busy     = (state == S_HDR) || (state == S_PIX) || (state == S_END);
   // In END, never pull more bytes than the marker still needs.
   assign end_room = {1'b0, end_cnt} + {2'b00, fill};
   assign in_ready = busy && (fill < 3'd5) && ((state != S_END) || (end_room < 5'd8));
   assign acc      = in_valid && in_ready;
   assign dec_step = (state == S_PIX) && (fill == 3'd5) && (!pix_valid || pix_ready)
                     && (pix_cnt != total);
   assign end_ret  = (state == S_END) && (fill != 3'd0);
   assign bad_cons = dec_step && (dec_consumed > fill);
   assign dim_full = {dim_sh, in_data};
   assign dim_bad  = (dim_full == 32'd0) || ((dim_full >> DIM_W) != 32'd0);

   for (genvar g = 0; g < 5; g++) begin : g_flat
      assign chunk_flat[8*g +: 8] = win[g];
   end

   always_comb begin
      case (hdr_cnt[1:0])
         2'd0:    magic_b = 8'h71;
         2'd1:    magic_b = 8'h6F;
         2'd2:    magic_b = 8'h69;
         default: magic_b = 8'h66;
      endcase
   end

   // Retire first (decoder step or one marker byte), then append any accepted byte.
   always_comb begin
      sh = 3'd0;
      if (dec_step)
         sh = dec_consumed;
      else if (end_ret)
         sh = 3'd1;
      base = fill - sh;
      idx  = 4'd0;
      for (int k = 0; k < 5; k++) begin
         idx        = 4'(k) + {1'b0, sh};
         nxt_win[k] = 8'h00;
         if (idx < 4'd5)
            nxt_win[k] = win[idx[2:0]];
      end
      win_acc = acc && (state != S_HDR);
      if (win_acc && (base < 3'd5))
         nxt_win[base] = in_data;
      nxt_fill = base + {2'b00, win_acc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         fill         <= 3'd0;
         for (int k = 0; k < 5; k++) win[k] <= 8'h00;
         hdr_cnt      <= 4'd0;
         end_cnt      <= 4'd0;
         dim_sh       <= 24'd0;
         total        <= '0;
         pix_cnt      <= '0;
         dec_clear    <= 1'b0;
         pix_valid    <= 1'b0;
         img_width    <= '0;
         img_height   <= '0;
         img_channels <= 8'h00;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         dec_clear <= 1'b0;
         if (((state == S_PIX) || (state == S_END)) && !bad_cons) begin
            win  <= nxt_win;
            fill <= nxt_fill;
         end
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state     <= S_HDR;
                  dec_clear <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  hdr_cnt   <= 4'd0;
                  end_cnt   <= 4'd0;
                  pix_cnt   <= '0;
                  fill      <= 3'd0;
                  pix_valid <= 1'b0;
               end
            end
            S_HDR: begin
               if (acc) begin
                  hdr_cnt <= hdr_cnt + 4'd1;
                  dim_sh  <= dim_full[23:0];
                  if ((hdr_cnt < 4'd4) && (in_data != magic_b)) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
                  if (hdr_cnt == 4'd7) begin
                     img_width <= dim_full[DIM_W-1:0];
                     if (dim_bad) begin
                        state <= S_ERR;
                        error <= 1'b1;
                     end
                  end
                  if (hdr_cnt == 4'd11) begin
                     img_height <= dim_full[DIM_W-1:0];
                     if (dim_bad) begin
                        state <= S_ERR;
                        error <= 1'b1;
                     end
                  end
                  if (hdr_cnt == 4'd12) begin
                     img_channels <= in_data;
                     if ((in_data != 8'd3) && (in_data != 8'd4)) begin
                        state <= S_ERR;
                        error <= 1'b1;
                     end
                  end
                  if (hdr_cnt == 4'd13) begin
                     total <= (2*DIM_W)'(img_width) * (2*DIM_W)'(img_height);
                     state <= S_PIX;
                  end
               end
            end
            S_PIX: begin
               if (bad_cons) begin
                  state     <= S_ERR;
                  error     <= 1'b1;
                  pix_valid <= 1'b0;
               end else if (dec_step) begin
                  pix_valid <= 1'b1;
                  pix_cnt   <= pix_cnt + 1'b1;
               end else if (pix_valid && pix_ready) begin
                  pix_valid <= 1'b0;
                  if (pix_cnt == total)
                     state <= S_END;
               end
            end
            S_END: begin
               if (end_ret) begin
                  if (win[0] != {7'd0, end_cnt == 4'd7}) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else begin
                     end_cnt <= end_cnt + 4'd1;
                     if (end_cnt == 4'd7) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qoi_stream_sequencer.sv
// Bench for qoi_stream_sequencer: the bench acts as stream source, decoder and pixel
// sink; a byte-offset model of the stream predicts every window and the final status.
module tb_qoi_stream_sequencer;

   localparam int DIM_W = 16;
   localparam logic [31:0] MAGIC = 32'h716F6966;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [39:0]      chunk_flat;
   logic [2:0]       dec_consumed = 3'd0;
   logic             dec_step;
   logic             dec_clear;
   logic             pix_valid;
   logic             pix_ready = 1'b0;
   logic [DIM_W-1:0] img_width;
   logic [DIM_W-1:0] img_height;
   logic [7:0]       img_channels;
   logic             busy;
   logic             done;
   logic             error;
   logic             start = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [7:0]  stream [$];
   int          cons [$];
   logic [31:0] hdr_w, hdr_h;
   logic [7:0]  hdr_ch;

   always #5 clk = ~clk;

   qoi_stream_sequencer #(.DIM_W(DIM_W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .chunk_flat(chunk_flat), .dec_consumed(dec_consumed), .dec_step(dec_step),
      .dec_clear(dec_clear), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .img_width(img_width), .img_height(img_height), .img_channels(img_channels),
      .busy(busy), .done(done), .error(error), .start(start)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic build_header(input logic [31:0] magic, input logic [31:0] w,
                               input logic [31:0] h, input logic [7:0] ch);
      stream.delete();
      cons.delete();
      hdr_w = w; hdr_h = h; hdr_ch = ch;
      for (int i = 0; i < 4; i++) stream.push_back(magic[31-8*i -: 8]);
      for (int i = 0; i < 4; i++) stream.push_back(w[31-8*i -: 8]);
      for (int i = 0; i < 4; i++) stream.push_back(h[31-8*i -: 8]);
      stream.push_back(ch);
      stream.push_back(8'h00);
   endtask

   task automatic add_pixel(input int c);
      for (int i = 0; i < c; i++) stream.push_back(8'($urandom));
      cons.push_back(c);
   endtask

   task automatic add_marker(input logic [7:0] last);
      for (int i = 0; i < 7; i++) stream.push_back(8'h00);
      stream.push_back(last);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("dec_clear_pulse", dec_clear, 1);
      check("busy_after_start", busy, 1);
   endtask

   task automatic run_image(input string tag, input int n_pix, input bit exp_err,
                            input int err_after, input int stall_at, input bit full_rate);
      int src = 0, steps = 0, acc_pix = 0, off = 0, cyc = 0, hdr_cyc = 0, idx = 0;
      int stall_left = 0;
      bit stall_used = 0, resume = 0, finished = 0;
      logic [39:0] exp_chunk;
      logic [39:0] held = '0;
      pulse_start();
      while (!finished && cyc < 3000) begin
         if (stall_at >= 0 && !stall_used && steps == stall_at) begin
            stall_used = 1; stall_left = 10; held = chunk_flat;
         end
         start        = (cyc == 20) && busy;
         in_valid     = (src < stream.size()) && (full_rate || $urandom_range(0, 3) != 0);
         in_data      = in_valid ? stream[src] : 8'($urandom);
         pix_ready    = (stall_left > 0) ? 1'b0 : (full_rate || $urandom_range(0, 2) != 0);
         dec_consumed = (steps < cons.size()) ? 3'(cons[steps]) : 3'd0;
         #1;
         check({tag, ":pix_valid"}, pix_valid, steps > acc_pix);
         if (cyc >= 1) check({tag, ":dec_clear_low"}, dec_clear, 0);
         if (stall_left > 0) begin
            check({tag, ":stall_valid"}, pix_valid, 1);
            check({tag, ":stall_step"}, dec_step, 0);
            check({tag, ":stall_win"}, chunk_flat, held);
            stall_left--;
            if (stall_left == 0) resume = 1;
         end else if (resume) begin
            check({tag, ":resume_step"}, dec_step, 1);
            resume = 0;
         end
         if (in_valid && in_ready) begin
            if (src == 13) hdr_cyc = cyc;
            src++;
         end
         if (dec_step) begin
            exp_chunk = '0;
            for (int j = 0; j < 5; j++) begin
               idx = 14 + off + j;
               exp_chunk[8*j +: 8] = (idx < stream.size()) ? stream[idx] : 8'h00;
            end
            check({tag, ":chunk"}, chunk_flat, exp_chunk);
            if (steps == 0) check({tag, ":first_step_lat"}, (cyc - hdr_cyc) >= 5, 1);
            if (steps < cons.size()) off += cons[steps];
            steps++;
         end
         if (pix_valid && pix_ready) acc_pix++;
         finished = done || error;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0; in_valid = 1'b0; pix_ready = 1'b0;
      check({tag, ":finished"}, finished, 1);
      check({tag, ":error"}, error, exp_err);
      check({tag, ":done"}, done, !exp_err);
      check({tag, ":in_ready_idle"}, in_ready, 0);
      check({tag, ":busy_idle"}, busy, 0);
      if (err_after >= 0) begin
         check({tag, ":err_byte"}, src, err_after);
         check({tag, ":no_step"}, steps, 0);
         check({tag, ":step_low"}, dec_step, 0);
      end
      if (!exp_err) begin
         check({tag, ":steps"}, steps, n_pix);
         check({tag, ":pixels"}, acc_pix, n_pix);
         check({tag, ":bytes"}, src, stream.size());
         check({tag, ":width"}, img_width, hdr_w[DIM_W-1:0]);
         check({tag, ":height"}, img_height, hdr_h[DIM_W-1:0]);
         check({tag, ":channels"}, img_channels, hdr_ch);
      end
   endtask

   task automatic reset_mid_pix();
      int src = 0, cyc = 0;
      build_header(MAGIC, 1, 1, 4);
      add_pixel(4);
      add_marker(8'h01);
      pulse_start();
      while (src < 17 && cyc < 200) begin
         in_valid = 1'b1; in_data = stream[src]; pix_ready = 1'b0;
         #1;
         if (in_ready) src++;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      check("rst_feed", src, 17);
      check("rst_pre_busy", busy, 1);
      check("rst_pre_win", chunk_flat[23:0], {stream[16], stream[15], stream[14]});
      check("rst_pre_step", dec_step, 0);
      rst = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_chunk", chunk_flat, 0);
      check("rst_step", dec_step, 0);
      check("rst_clear", dec_clear, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_dims", {img_width, img_height, img_channels}, 0);
      check("rst_status", {busy, done, error}, 0);
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      int w, h;
      #1;
      check("reset_in_ready", in_ready, 0);
      check("reset_chunk", chunk_flat, 0);
      check("reset_status", {busy, done, error, dec_step, dec_clear, pix_valid}, 0);
      check("reset_dims", {img_width, img_height, img_channels}, 0);
      @(negedge clk); rst = 1'b0;

      build_header(MAGIC, 1, 1, 4);
      stream.push_back(8'hFE); stream.push_back(8'h10);
      stream.push_back(8'h20); stream.push_back(8'h30);
      cons.push_back(4);
      add_marker(8'h01);
      run_image("rgb1x1", 1, 0, -1, -1, 1);

      build_header(MAGIC, 2, 2, 4);
      stream.push_back(8'hC3);
      cons.push_back(1); cons.push_back(0); cons.push_back(0); cons.push_back(0);
      add_marker(8'h01);
      run_image("run2x2", 4, 0, -1, -1, 1);

      build_header(32'h716F6967, 1, 1, 4);
      run_image("bad_magic", 0, 1, 4, -1, 1);

      build_header(MAGIC, 32'h0001_0000, 1, 4);
      run_image("wide", 0, 1, 8, -1, 1);

      build_header(MAGIC, 1, 0, 4);
      run_image("height0", 0, 1, 12, -1, 1);

      build_header(MAGIC, 1, 1, 5);
      run_image("chan5", 0, 1, 13, -1, 1);

      build_header(MAGIC, 2, 2, 3);
      add_pixel(2); add_pixel(0); add_pixel(0); add_pixel(1);
      add_marker(8'h01);
      run_image("stall", 4, 0, -1, 3, 1);

      reset_mid_pix();
      build_header(MAGIC, 1, 1, 3);
      add_pixel(4);
      add_marker(8'h01);
      run_image("after_rst", 1, 0, -1, -1, 0);

      build_header(MAGIC, 1, 1, 4);
      add_pixel(4);
      add_marker(8'h02);
      run_image("bad_marker", 1, 1, -1, -1, 0);

      for (int n = 0; n < 6; n++) begin
         w = $urandom_range(1, 3);
         h = $urandom_range(1, 3);
         build_header(MAGIC, w, h, 8'(3 + $urandom_range(0, 1)));
         for (int p = 0; p < w * h; p++) add_pixel($urandom_range(0, 5));
         add_marker(8'h01);
         run_image("random", w * h, 0, -1, -1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/qoi_stream_sequencer.md
Name: qoi_stream_sequencer

Overview:
Sequences a QOI byte stream through the `qoi_decoder` datapath.
- Parses the 14-byte QOI header.
- Keeps a 5-byte chunk window filled for the decoder and retires the bytes the decoder reports as consumed.
- Issues one decoder step per output pixel and counts pixels against width*height.
- Checks the 8-byte end marker.
- Sits between the byte-stream source (DMA/FIFO) and the pixel sink (framebuffer writer).

Parameters:
- DIM_W, 16, maximum bits for width and height; a header with any higher bit set is an error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  sequencer accepts byte this cycle
- chunk_flat  output  40  window to decoder; byte k at bits [8k+7:8k]; byte 0 is the oldest
- dec_consumed  input  3  decoder's chunk_len_consumed for the current window, combinational, 0..5
- dec_step  output  1  decoder advances one pixel at this clock edge
- dec_clear  output  1  one-cycle pulse to reset decoder state (index table, previous pixel) at image start
- pix_valid  output  1  decoder r/g/b/a hold a new pixel
- pix_ready  input  1  sink accepts pixel
- img_width  output  DIM_W  parsed width
- img_height  output  DIM_W  parsed height
- img_channels  output  8  parsed channels byte
- busy  output  1  state is not IDLE/DONE/ERR
- done  output  1  image finished, end marker verified; sticky until start
- error  output  1  sticky until start
- start  input  1  begin a new image; ignored while busy

Behaviour:
- Reset values: all outputs 0; fill count 0; window bytes 0; state IDLE; pixel counter 0.
- Window: 5-byte shift buffer with fill count 0..5.
  - in_ready = busy && (fill < 5).
  - A byte is accepted when in_valid && in_ready and is written at index fill.
- dec_step retire: when dec_step=1, the window shifts down by dec_consumed and fill -= dec_consumed.
  - A byte accepted in the same cycle lands at index (fill - dec_consumed).
  - dec_consumed > fill is an error.
- States:
  - IDLE: on start, go to HDR. Pulse dec_clear. Clear done, error, counters and fill.
  - HDR: consume 14 bytes directly from the input without using the window.
    - Bytes 0-3 must equal 0x71 0x6F 0x69 0x66; on mismatch go to ERR.
    - Width and height are 32-bit big-endian. Width=0, height=0, or any bit at or above DIM_W set: ERR.
    - Channels must be 3 or 4. Colorspace is ignored.
    - On success: total = width*height (2*DIM_W bits), go to PIX.
  - PIX: dec_step = (fill == 5) && (!pix_valid || pix_ready).
    - pix_valid is set the cycle after dec_step and cleared on pix_valid && pix_ready with no new step.
    - An accept and a new step in the same cycle keep pix_valid at 1.
    - The pixel counter increments on each dec_step.
    - dec_consumed = 0 is legal: a run continuation emits a pixel without consuming bytes.
    - When the counter reaches total and the final pixel is accepted, go to END. No further dec_step.
  - END: the remaining window bytes plus further input, 8 bytes total, must equal 00 00 00 00 00 00 00 01.
    - All 8 matching: go to DONE.
    - Any mismatch: go to ERR.
  - DONE: done=1, in_ready=0. Wait for start.
  - ERR: error=1, in_ready=0, dec_step=0, pix_valid=0. Wait for start.
- Window always fills: the stream guarantees at least 8 bytes after the last chunk, so the window can always reach fill==5 during PIX.
- Latency: first dec_step no earlier than 5 cycles after the last header byte. Throughput is 1 pixel/cycle when the input and the sink never stall.
- Reset asserted mid-image: immediate return to the reset state, with no further pulses.
- start while busy: ignored.

Test Plan:
- 1x1 image, channels 4, with one QOI_OP_RGB chunk FE 10 20 30 followed by the end marker:
  - one dec_step with consumed=4;
  - pix_valid one cycle later;
  - done=1 after 8 marker bytes, error=0.
- 2x2 image with a run chunk C3, decoder reporting consumed=1 on the first step and 0 on the next three:
  - exactly 4 dec_step pulses, 4 accepted pixels;
  - then END and done.
- Header magic 71 6F 69 67:
  - error=1 after the 4th byte;
  - in_ready=0, no dec_step.
- Width 0x00010000 with DIM_W=16: error=1.
- Height 0 with DIM_W=16: error=1.
- pix_ready held low for 10 cycles mid-image:
  - pix_valid stays high;
  - no dec_step and the window is unchanged;
  - decoding resumes the cycle pix_ready rises.
- Reset mid-PIX with fill=3:
  - all outputs 0 immediately;
  - start then decodes a fresh 1x1 image correctly.
- End marker ending in 02 instead of 01: error=1, done=0.
